// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives instruction memory, queues {pc, instr} for decode.
// Optional perf counters (perf_fetched, perf_stall) are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic          pop, push, full;

    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO can still accept a fetch when the head leaves in the same cycle.
    assign push      = !redirect_valid & (!full | pop);
    assign imem_addr = pc_q;

    // Empty FIFO presents zeros so decode never sees stale or X data.
    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        if (out_valid) begin
            out_instr = mem_q[rd_ptr_q].instr;
            out_pc    = mem_q[rd_ptr_q].pc;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: pc_q, instr: imem_instr};
                wr_ptr_d        = wr_ptr_q + 1'b1;
                pc_d            = pc_q + 32'd4;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'd0, push};
        perf_stall_d   = perf_stall_q + {31'd0, full & !pop & !redirect_valid};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns {addr[15:0],16'hC0DE}.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign imem_instr = {imem_addr[15:0], 16'hC0DE};

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        logic [31:0] ei;
        ei = {pc[15:0], 16'hC0DE};
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_instr"}, out_instr, ei);
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // Streaming with decode always ready
        rst = 1'b0; out_ready = 1'b1;
        chk("s1_first_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 13; i++) begin
            tick();
            chk_head("s1", 32'(4 * i));
        end

        // Back-pressure fill
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("s2_full_addr", imem_addr, 32'd16);
        chk_head("s2_full", 32'd0);
        tick();
        tick();
        chk("s2_stall_addr", imem_addr, 32'd16);
        chk("s2_stall_pc", out_pc, 32'd0);
`ifdef FETCH_PERF_EN
        chk("s2_perf_stall", perf_stall, 32'd2);
        chk("s2_perf_fetched", perf_fetched, 32'd4);
`endif
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) chk("s2_fullpop_push", imem_addr, 32'd20);
            chk_head("s2_drain", 32'(4 * k));
        end

        // Mid-stream redirect to a misaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        chk("s3_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("s3_addr", imem_addr, 32'h100);
        tick();
        chk_head("s3_target", 32'h100);

        // Build FIFO holding 8,12, then redirect with a concurrent pop
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd8;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("s4_addr", imem_addr, 32'd16);
        chk_head("s4_head", 32'd8);
        redirect_valid = 1'b1; redirect_pc = 32'h200; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("s4_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("s4_addr2", imem_addr, 32'h200);
        tick();
        chk_head("s4_target", 32'h200);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        chk("s5_addr", imem_addr, 32'hFFFF_FFF8);
        chk("s5_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk_head("s5_a", 32'hFFFF_FFF8);
        chk("s5_addr_b", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk_head("s5_b", 32'hFFFF_FFFC);
        chk("s5_addr_wrap", imem_addr, 32'd0);
        tick();
        chk_head("s5_c", 32'd0);

        // Reset dominates a redirect while full
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk_head("s6_full", 32'd0);
        chk("s6_full_addr", imem_addr, 32'd16);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        rst = 1'b0; redirect_valid = 1'b0;
        chk("s6_valid", {31'd0, out_valid}, 32'd0);
        chk("s6_addr", imem_addr, 32'd0);
        chk("s6_pc", out_pc, 32'd0);
        chk("s6_instr", out_instr, 32'd0);
`ifdef FETCH_PERF_EN
        chk("s6_perf_fetched", perf_fetched, 32'd0);
        chk("s6_perf_stall", perf_stall, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
